// File: rtl/rs232_rx_frame_ctrl.sv
// Frame assembler behind the rs232_rx byte receiver: SYNC, CMD, LEN, payload, CHK.
// Holds the receiver configuration steady while a frame is in flight and hands validated frames to the host.
module rs232_rx_frame_ctrl #(
  parameter int          MAX_LEN   = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          TIMEOUT   = 50000,
  parameter logic [14:0] BAUD_RST  = 15'd5208
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        eor_i,
  input  logic [7:0]  data_i,
  input  logic        pcheck_i,
  input  logic [14:0] baud_cfg_i,
  input  logic        psel_cfg_i,
  output logic [14:0] baud_o,
  output logic        psel_o,
  output logic        frame_valid_o,
  input  logic        frame_ack_i,
  output logic [7:0]  cmd_o,
  output logic [3:0]  len_o,
  input  logic [3:0]  rd_addr_i,
  output logic [7:0]  rd_data_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [2:0]  err_code_o
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  // Expiry fires on the edge where the counter would reach TIMEOUT-1.
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 2);
  localparam logic [7:0]     LEN_MAX  = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN, S_DATA, S_CHK, S_HOLD
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [7:0]    sum;
  logic [3:0]    idx;
  logic [7:0]    pay [MAX_LEN];
  logic          in_frame;
  logic          expire;
  logic          set_err;
  logic [2:0]    err_sel;
  logic          ld_cmd, ld_len, wr_pay;

  assign in_frame      = (state == S_CMD) || (state == S_LEN) ||
                         (state == S_DATA) || (state == S_CHK);
  assign busy_o        = in_frame;
  assign frame_valid_o = (state == S_HOLD);
  assign expire        = in_frame && !eor_i && (cnt == CNT_LAST);

  always_comb begin
    state_next = state;
    set_err    = 1'b0;
    err_sel    = 3'd0;
    ld_cmd     = 1'b0;
    ld_len     = 1'b0;
    wr_pay     = 1'b0;
    case (state)
      S_IDLE: begin
        if (eor_i && !pcheck_i && (data_i == SYNC_BYTE)) state_next = S_CMD;
      end
      S_HOLD: begin
        if (frame_ack_i) state_next = S_IDLE;
        // The held frame is kept; the intruding byte is only reported.
        if (eor_i) begin
          set_err = 1'b1;
          err_sel = 3'd5;
        end
      end
      S_CMD, S_LEN, S_DATA, S_CHK: begin
        if (eor_i && pcheck_i) begin
          set_err    = 1'b1;
          err_sel    = 3'd1;
          state_next = S_IDLE;
        end else if (eor_i) begin
          case (state)
            S_CMD: begin
              ld_cmd     = 1'b1;
              state_next = S_LEN;
            end
            S_LEN: begin
              if (data_i > LEN_MAX) begin
                set_err    = 1'b1;
                err_sel    = 3'd2;
                state_next = S_IDLE;
              end else begin
                ld_len     = 1'b1;
                state_next = (data_i == 8'd0) ? S_CHK : S_DATA;
              end
            end
            S_DATA: begin
              wr_pay = 1'b1;
              if ((idx + 4'd1) == len_o) state_next = S_CHK;
            end
            S_CHK: begin
              if (data_i == sum) begin
                state_next = S_HOLD;
              end else begin
                set_err    = 1'b1;
                err_sel    = 3'd3;
                state_next = S_IDLE;
              end
            end
            default: state_next = S_IDLE;
          endcase
        end else if (expire) begin
          set_err    = 1'b1;
          err_sel    = 3'd4;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sum        <= 8'd0;
      idx        <= 4'd0;
      cmd_o      <= 8'd0;
      len_o      <= 4'd0;
      baud_o     <= BAUD_RST;
      psel_o     <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= 3'd0;
      for (int i = 0; i < MAX_LEN; i++) pay[i] <= 8'd0;
    end else begin
      state <= state_next;
      err_o <= set_err;
      if (set_err) err_code_o <= err_sel;
      if (state == S_IDLE) begin
        baud_o <= baud_cfg_i;
        psel_o <= psel_cfg_i;
      end
      if (eor_i || !in_frame) cnt <= '0;
      else                    cnt <= cnt + CW'(1);
      if (ld_cmd) begin
        cmd_o <= data_i;
        sum   <= data_i;
      end
      if (ld_len) begin
        len_o <= data_i[3:0];
        sum   <= sum + data_i;
        idx   <= 4'd0;
      end
      if (wr_pay) begin
        sum <= sum + data_i;
        idx <= idx + 4'd1;
        for (int i = 0; i < MAX_LEN; i++) begin
          if (idx == 4'(i)) pay[i] <= data_i;
        end
      end
    end
  end

  always_comb begin
    rd_data_o = 8'd0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((rd_addr_i == 4'(i)) && (rd_addr_i < len_o)) rd_data_o = pay[i];
    end
  end

endmodule

// File: tb/tb_rs232_rx_frame_ctrl.sv
// Bench for rs232_rx_frame_ctrl: directed frame scenarios plus randomized frames
// checked against a frame-level model built from byte queues.
module tb_rs232_rx_frame_ctrl;

  localparam int MAX_LEN = 8;
  localparam int TMO     = 100;

  logic        clk = 1'b0;
  logic        rst, eor, pcheck, psel_cfg, psel, frame_valid, frame_ack, busy, err;
  logic [7:0]  data, cmd, rd_data;
  logic [14:0] baud_cfg, baud;
  logic [3:0]  len, rd_addr;
  logic [2:0]  err_code;

  int checks = 0;
  int errors = 0;

  rs232_rx_frame_ctrl #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO), .BAUD_RST(15'd5208)) dut (
    .clk_i(clk), .rst_i(rst), .eor_i(eor), .data_i(data), .pcheck_i(pcheck),
    .baud_cfg_i(baud_cfg), .psel_cfg_i(psel_cfg), .baud_o(baud), .psel_o(psel),
    .frame_valid_o(frame_valid), .frame_ack_i(frame_ack), .cmd_o(cmd), .len_o(len),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .busy_o(busy), .err_o(err), .err_code_o(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Returns at the falling edge after the DUT sampled the byte.
  task automatic send_byte(input logic [7:0] b, input logic pc);
    @(negedge clk); eor = 1'b1; data = b; pcheck = pc;
    @(negedge clk); eor = 1'b0; pcheck = 1'b0;
  endtask

  task automatic ack_frame;
    @(negedge clk); frame_ack = 1'b1;
    @(negedge clk); frame_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; eor = 1'b0; data = 8'd0; pcheck = 1'b0; frame_ack = 1'b0;
    baud_cfg = 15'd5208; psel_cfg = 1'b0; rd_addr = 4'd0;
    repeat (3) @(negedge clk);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", frame_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %0h exp 0", err); end
    checks++; if (err_code !== 3'd0) begin errors++; $display("FAIL rst_code got %0h exp 0", err_code); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h exp 0", busy); end
    checks++; if (cmd !== 8'd0 || len !== 4'd0) begin errors++; $display("FAIL rst_cmd_len got %0h/%0h exp 0/0", cmd, len); end
    checks++; if (baud !== 15'd5208 || psel !== 1'b0) begin errors++; $display("FAIL rst_cfg got %0d/%0h exp 5208/0", baud, psel); end
    checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL rst_rd got %0h exp 0", rd_data); end
    rst = 1'b1;
  endtask

  task automatic test_basic;
    logic [7:0] bq[$];
    ack_frame();
    checks++; if (frame_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_ack got %0h/%0h exp 0/0", frame_valid, busy); end
    bq = '{8'hA5, 8'h03, 8'h02, 8'h11, 8'h22, 8'h38};
    foreach (bq[i]) begin
      send_byte(bq[i], 1'b0);
      checks++; if (frame_valid !== (i == 5)) begin errors++; $display("FAIL basic_valid byte %0d got %0h exp %0h", i, frame_valid, (i == 5)); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err byte %0d got %0h exp 0", i, err); end
    end
    checks++; if (cmd !== 8'h03 || len !== 4'd2) begin errors++; $display("FAIL basic_cmd_len got %0h/%0h exp 3/2", cmd, len); end
    rd_addr = 4'd0; #1;
    checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL basic_rd0 got %0h exp 11", rd_data); end
    rd_addr = 4'd1; #1;
    checks++; if (rd_data !== 8'h22) begin errors++; $display("FAIL basic_rd1 got %0h exp 22", rd_data); end
    rd_addr = 4'd2; #1;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL basic_rd2 got %0h exp 0", rd_data); end
    ack_frame();
    checks++; if (frame_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_ack got %0h/%0h exp 0/0", frame_valid, busy); end
  endtask

  task automatic test_zero_len;
    logic [7:0] bq[$];
    bq = '{8'h7E, 8'hA5, 8'h01, 8'h00, 8'h01};
    foreach (bq[i]) begin
      send_byte(bq[i], 1'b0);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL zero_err byte %0d got %0h exp 0", i, err); end
    end
    checks++; if (frame_valid !== 1'b1 || len !== 4'd0 || cmd !== 8'h01) begin errors++; $display("FAIL zero_frame got %0h/%0h/%0h exp 1/0/1", frame_valid, len, cmd); end
    ack_frame();
  endtask

  task automatic test_len_chk_err;
    logic [7:0] bq[$];
    bq = '{8'hA5, 8'h01, 8'h09};
    foreach (bq[i]) send_byte(bq[i], 1'b0);
    checks++; if (err !== 1'b1 || err_code !== 3'd2 || busy !== 1'b0) begin errors++; $display("FAIL len_err got %0h/%0h/%0h exp 1/2/0", err, err_code, busy); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL len_err_pulse got %0h exp 0", err); end
    bq = '{8'hA5, 8'h05, 8'h01, 8'h7F, 8'h85};
    foreach (bq[i]) send_byte(bq[i], 1'b0);
    rd_addr = 4'd0; #1;
    checks++; if (frame_valid !== 1'b1 || rd_data !== 8'h7F) begin errors++; $display("FAIL len_recover got %0h/%0h exp 1/7f", frame_valid, rd_data); end
    ack_frame();
    bq = '{8'hA5, 8'h03, 8'h02, 8'h11, 8'h22, 8'h39};
    foreach (bq[i]) send_byte(bq[i], 1'b0);
    checks++; if (err !== 1'b1 || err_code !== 3'd3 || frame_valid !== 1'b0) begin errors++; $display("FAIL chk_err got %0h/%0h/%0h exp 1/3/0", err, err_code, frame_valid); end
    bq = '{8'hA5, 8'h03, 8'h02, 8'h11, 8'h22, 8'h38};
    foreach (bq[i]) send_byte(bq[i], 1'b0);
    checks++; if (frame_valid !== 1'b1 || cmd !== 8'h03) begin errors++; $display("FAIL chk_recover got %0h/%0h exp 1/3", frame_valid, cmd); end
    ack_frame();
  endtask

  task automatic test_timeout;
    int k;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    k = 0;
    while (k < 3 * TMO && err !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k != TMO - 1) begin errors++; $display("FAIL tmo_delay got %0d exp %0d", k, TMO - 1); end
    checks++; if (err_code !== 3'd4 || busy !== 1'b0) begin errors++; $display("FAIL tmo_state got %0h/%0h exp 4/0", err_code, busy); end
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    repeat (TMO - 3) @(negedge clk);
    send_byte(8'h00, 1'b0);
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_race got %0h/%0h exp 0/1", err, busy); end
    send_byte(8'h03, 1'b0);
    checks++; if (frame_valid !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL tmo_race_frame got %0h/%0h exp 1/0", frame_valid, err); end
    ack_frame();
  endtask

  task automatic test_parity;
    psel_cfg = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (psel !== 1'b1) begin errors++; $display("FAIL psel_load got %0h exp 1", psel); end
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h02, 1'b1);
    checks++; if (err !== 1'b1 || err_code !== 3'd1 || busy !== 1'b0) begin errors++; $display("FAIL parity got %0h/%0h/%0h exp 1/1/0", err, err_code, busy); end
    psel_cfg = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_baud;
    baud_cfg = 15'd5208;
    repeat (2) @(negedge clk);
    send_byte(8'hA5, 1'b0);
    baud_cfg = 15'd434;
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    checks++; if (baud !== 15'd5208) begin errors++; $display("FAIL baud_mid got %0d exp 5208", baud); end
    send_byte(8'h03, 1'b0);
    checks++; if (baud !== 15'd5208 || frame_valid !== 1'b1) begin errors++; $display("FAIL baud_hold got %0d/%0h exp 5208/1", baud, frame_valid); end
    ack_frame();
    checks++; if (baud !== 15'd5208) begin errors++; $display("FAIL baud_ack got %0d exp 5208", baud); end
    @(negedge clk);
    checks++; if (baud !== 15'd434) begin errors++; $display("FAIL baud_idle got %0d exp 434", baud); end
  endtask

  task automatic test_overrun;
    logic [7:0] bq[$];
    bq = '{8'hA5, 8'h07, 8'h01, 8'h5A, 8'h62};
    foreach (bq[i]) send_byte(bq[i], 1'b0);
    send_byte(8'hA5, 1'b0);
    rd_addr = 4'd0; #1;
    checks++; if (err !== 1'b1 || err_code !== 3'd5) begin errors++; $display("FAIL overrun_err got %0h/%0h exp 1/5", err, err_code); end
    checks++; if (frame_valid !== 1'b1 || cmd !== 8'h07 || len !== 4'd1 || rd_data !== 8'h5A) begin
      errors++; $display("FAIL overrun_frame got %0h/%0h/%0h/%0h exp 1/7/1/5a", frame_valid, cmd, len, rd_data); end
    ack_frame();
  endtask

  task automatic test_reset_mid;
    logic [7:0] bq[$];
    bq = '{8'hA5, 8'h03, 8'h04, 8'h11, 8'h22};
    foreach (bq[i]) send_byte(bq[i], 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %0h exp 1", busy); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rd_addr = 4'd0; #1;
    checks++; if (busy !== 1'b0 || frame_valid !== 1'b0 || err !== 1'b0 || err_code !== 3'd0) begin
      errors++; $display("FAIL rstmid_ctl got %0h/%0h/%0h/%0h exp 0/0/0/0", busy, frame_valid, err, err_code); end
    checks++; if (cmd !== 8'd0 || len !== 4'd0 || rd_data !== 8'd0) begin errors++; $display("FAIL rstmid_frame got %0h/%0h/%0h exp 0/0/0", cmd, len, rd_data); end
    checks++; if (baud !== 15'd5208 || psel !== 1'b0) begin errors++; $display("FAIL rstmid_cfg got %0d/%0h exp 5208/0", baud, psel); end
  endtask

  // Builds a frame (junk, SYNC, CMD, LEN, payload, CHK), derives the expected outcome
  // from the framing rules, then streams it with random gaps.
  task automatic test_random;
    for (int it = 0; it < 25; it++) begin
      logic [7:0] q[$];
      logic       pq[$];
      logic [7:0] pl[$];
      logic [7:0] b, cmd_v, s;
      int         ln, err_pos, nj;
      logic [2:0] exp_code;
      logic       exp_ok;
      err_pos = -1; exp_code = 3'd0; exp_ok = 1'b0;
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        if ($urandom_range(0, 1) == 1) begin
          q.push_back(8'hA5); pq.push_back(1'b1);
        end else begin
          b = 8'($urandom_range(0, 254));
          if (b >= 8'hA5) b = b + 8'd1;
          q.push_back(b); pq.push_back(1'($urandom_range(0, 1)));
        end
      end
      cmd_v = 8'($urandom_range(0, 255));
      ln = $urandom_range(0, MAX_LEN + 2);
      q.push_back(8'hA5); pq.push_back(1'b0);
      q.push_back(cmd_v); pq.push_back(1'b0);
      q.push_back(8'(ln)); pq.push_back(1'b0);
      if (ln > MAX_LEN) begin
        err_pos = q.size() - 1; exp_code = 3'd2;
      end else begin
        s = cmd_v + 8'(ln);
        for (int j = 0; j < ln; j++) begin
          b = 8'($urandom_range(0, 255));
          pl.push_back(b); q.push_back(b); pq.push_back(1'b0);
          s = s + b;
        end
        if ($urandom_range(0, 3) == 0) begin
          q.push_back(s ^ 8'($urandom_range(1, 255))); pq.push_back(1'b0);
          err_pos = q.size() - 1; exp_code = 3'd3;
        end else begin
          q.push_back(s); pq.push_back(1'b0);
          exp_ok = 1'b1;
        end
      end
      foreach (q[i]) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_byte(q[i], pq[i]);
        checks++; if (err !== (i == err_pos)) begin errors++; $display("FAIL rnd_err it %0d byte %0d got %0h exp %0h", it, i, err, (i == err_pos)); end
        checks++; if (frame_valid !== (exp_ok && i == q.size() - 1)) begin errors++; $display("FAIL rnd_valid it %0d byte %0d got %0h", it, i, frame_valid); end
      end
      if (!exp_ok) begin
        checks++; if (err_code !== exp_code) begin errors++; $display("FAIL rnd_code it %0d got %0h exp %0h", it, err_code, exp_code); end
      end else begin
        checks++; if (cmd !== cmd_v || len !== 4'(ln)) begin errors++; $display("FAIL rnd_hdr it %0d got %0h/%0h exp %0h/%0h", it, cmd, len, cmd_v, ln); end
        for (int a = 0; a < 16; a++) begin
          rd_addr = 4'(a); #1;
          checks++;
          if (rd_data !== ((a < ln) ? pl[a] : 8'd0)) begin
            errors++; $display("FAIL rnd_rd it %0d addr %0d got %0h exp %0h", it, a, rd_data, ((a < ln) ? pl[a] : 8'd0));
          end
        end
        ack_frame();
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rnd_ack it %0d got %0h exp 0", it, frame_valid); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_len_chk_err();
    test_timeout();
    test_parity();
    test_baud();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
